// File: rtl/btn_press_gen.sv
// Button-press generator: takes press commands over valid/ready and drives a clean,
// registered button level (press of programmed length, then a fixed release gap).
module btn_press_gen #(
    parameter int NrBiti  = 6,
    parameter int T_SHORT = 5,
    parameter int T_NORM  = 10,
    parameter int T_LONG  = 20,
    parameter int T_GAP   = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    input  logic [1:0]        cmd_type_i,
    input  logic [NrBiti-1:0] cmd_len_i,
    output logic              cmd_ready_o,
    input  logic              abort_i,
    output logic              btn_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              aborted_o,
    output logic [7:0]        press_cnt_o,
    output logic [1:0]        dbg_state_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRESS = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [NrBiti-1:0] LEN_SHORT = NrBiti'(T_SHORT);
    localparam logic [NrBiti-1:0] LEN_NORM  = NrBiti'(T_NORM);
    localparam logic [NrBiti-1:0] LEN_LONG  = NrBiti'(T_LONG);
    localparam logic [NrBiti-1:0] GAP_LOAD  = NrBiti'(T_GAP - 1);
    localparam logic [NrBiti-1:0] ONE       = NrBiti'(1);
    localparam logic [NrBiti-1:0] ZERO      = '0;

    logic [1:0]        state, state_d;
    logic [NrBiti-1:0] cnt, cnt_d;
    logic              abort_flag, abort_flag_d;
    logic [NrBiti-1:0] len_sel;
    logic              accept;
    logic              finish;

    // Handshake: a command is taken on a rising edge where cmd_valid_i and
    // cmd_ready_o are both high; cmd_* is ignored otherwise, nothing is queued.
    assign cmd_ready_o = (state == S_IDLE);
    assign busy_o      = (state != S_IDLE);
    assign accept      = cmd_valid_i & cmd_ready_o;
    assign finish      = (state == S_GAP) && (cnt == ZERO);
    assign dbg_state_o = state;

    always_comb begin
        len_sel = LEN_NORM;
        case (cmd_type_i)
            2'b00:   len_sel = LEN_SHORT;
            2'b01:   len_sel = LEN_NORM;
            2'b10:   len_sel = LEN_LONG;
            default: len_sel = (cmd_len_i == ZERO) ? ONE : cmd_len_i;
        endcase
    end

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        abort_flag_d = abort_flag;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_d      = S_PRESS;
                    cnt_d        = len_sel - ONE;
                    abort_flag_d = 1'b0;
                end
            end
            S_PRESS: begin
                // An abort in the final press cycle lands in the same place as a
                // normal finish; only the flag differs.
                if (abort_i || cnt == ZERO) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                    if (abort_i) abort_flag_d = 1'b1;
                end else begin
                    cnt_d = cnt - ONE;
                end
            end
            S_GAP: begin
                if (cnt == ZERO) state_d = S_IDLE;
                else             cnt_d   = cnt - ONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            abort_flag  <= 1'b0;
            btn_o       <= 1'b0;
            done_o      <= 1'b0;
            aborted_o   <= 1'b0;
            press_cnt_o <= 8'd0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            abort_flag <= abort_flag_d;
            btn_o      <= (state_d == S_PRESS);
            done_o     <= finish;
            aborted_o  <= finish & abort_flag;
            if (finish && !abort_flag) press_cnt_o <= press_cnt_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_btn_press_gen.sv
// Directed bench for btn_press_gen: stimulus pushes expected completions, a monitor
// measures press/gap lengths on btn_o and checks each done_o against the queue.
module tb_btn_press_gen;

    localparam int NB    = 6;
    localparam int T_GAP = 8;

    logic          clk;
    logic          rst_i;
    logic          cmd_valid;
    logic [1:0]    cmd_type;
    logic [NB-1:0] cmd_len;
    logic          cmd_ready;
    logic          abort;
    logic          btn;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [7:0]    press_cnt;
    logic [1:0]    dbg_state;

    btn_press_gen #(
        .NrBiti(NB), .T_SHORT(5), .T_NORM(10), .T_LONG(20), .T_GAP(T_GAP)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .cmd_valid_i(cmd_valid), .cmd_type_i(cmd_type),
        .cmd_len_i(cmd_len), .cmd_ready_o(cmd_ready), .abort_i(abort), .btn_o(btn),
        .busy_o(busy), .done_o(done), .aborted_o(aborted), .press_cnt_o(press_cnt),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int fail_cnt  = 0;

    // expected completion: [16] aborted, [15:8] press count, [7:0] high length
    logic [16:0] exp_q[$];
    logic [7:0]  exp_cnt = 8'd0;

    int high_run = 0, low_run = 0, last_high = 0, last_low_run = 0;
    logic prev_btn = 1'b0;

    task automatic check(input string name, input int got, input int req);
        tests_run++;
        if (got != req) begin
            fail_cnt++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic push_exp(input logic ab, input int high);
        if (!ab) exp_cnt = exp_cnt + 8'd1;
        exp_q.push_back({ab, exp_cnt, 8'(high)});
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst_i) begin
            high_run = 0;
            low_run  = 0;
            prev_btn = 1'b0;
        end else begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("aborted_o", int'(aborted), int'(e[16]));
                    check("press_cnt_o", int'(press_cnt), int'(e[15:8]));
                    check("press_len", last_high, int'(e[7:0]));
                    check("gap_len", low_run, T_GAP);
                end
            end
            if (btn) begin
                if (!prev_btn) begin
                    last_low_run = low_run;
                    high_run     = 0;
                end
                high_run++;
                low_run = 0;
            end else begin
                if (prev_btn) last_high = high_run;
                low_run++;
            end
            prev_btn = btn;
        end
    end

    // driver tasks
    task automatic send_cmd(input logic [1:0] t, input logic [NB-1:0] len);
        int budget;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_len   = len;
        budget    = 0;
        while (!cmd_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check("accept_in_budget", int'(budget < 200), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int budget;
        budget = 0;
        @(negedge clk);
        while (!done && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        check("done_in_budget", int'(budget < 300), 1);
    endtask

    initial begin
        rst_i     = 1'b0;
        cmd_valid = 1'b0;
        cmd_type  = 2'b00;
        cmd_len   = '0;
        abort     = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check("rst_btn", int'(btn), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_done", int'(done), 0);
        check("rst_aborted", int'(aborted), 0);
        check("rst_press_cnt", int'(press_cnt), 0);
        check("rst_state", int'(dbg_state), 0);

        // normal press: 10 high, 8 low, done
        push_exp(1'b0, 10);
        send_cmd(2'b01, '0);
        @(negedge clk);
        check("busy_in_press", int'(busy), 1);
        check("ready_in_press", int'(cmd_ready), 0);
        wait_done();

        // back-to-back short then long with valid held
        push_exp(1'b0, 5);
        push_exp(1'b0, 20);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_type  = 2'b00;
        @(posedge clk);
        #1 cmd_type = 2'b10;
        wait_done();
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_done();
        check("b2b_low_cycles", last_low_run, T_GAP + 1);

        // custom lengths, including the zero clamp and the maximum
        push_exp(1'b0, 1);
        send_cmd(2'b11, 6'd0);
        wait_done();
        push_exp(1'b0, 63);
        send_cmd(2'b11, 6'd63);
        wait_done();

        // abort on 4th cycle of a long press, then an abort during gap
        push_exp(1'b1, 4);
        send_cmd(2'b10, '0);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("btn_after_abort", int'(btn), 0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done();

        // abort in the last cycle of a short press
        push_exp(1'b1, 5);
        send_cmd(2'b00, '0);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done();

        // command pulsed while busy is dropped
        push_exp(1'b0, 10);
        send_cmd(2'b01, '0);
        repeat (3) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_type  = 2'b00;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done();
        repeat (30) @(negedge clk);
        check("no_extra_press", int'(busy), 0);

        // 256 normal presses: counter wraps back to its starting value
        for (int i = 0; i < 256; i++) begin
            push_exp(1'b0, 10);
            send_cmd(2'b01, '0);
            wait_done();
        end
        check("wrap_press_cnt", int'(press_cnt), 6);

        // asynchronous reset mid-press
        send_cmd(2'b01, '0);
        repeat (3) @(negedge clk);
        check("btn_before_rst", int'(btn), 1);
        #2 rst_i = 1'b0;
        #1;
        check("async_rst_btn", int'(btn), 0);
        check("async_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        check("post_rst_ready", int'(cmd_ready), 1);
        check("post_rst_press_cnt", int'(press_cnt), 0);
        repeat (30) @(negedge clk);
        check("post_rst_btn", int'(btn), 0);

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule

// File: doc/btn_press_gen.md
Name: btn_press_gen

Overview:
Synthesizable button-press generator. It is the driving end of the button interface consumed by drv_btn. It accepts press commands over a valid/ready handshake and drives a clean button level: held high for a programmed number of clocks, then held low for a mandatory release gap. It is used for in-system self-test of drv_btn and for scripted stimulus in place of the behavioural button model.

Parameters:
NrBiti, 6, width of the press/gap duration counter and of cmd_len_i
T_SHORT, 5, press length in clocks for cmd_type 2'b00
T_NORM, 10, press length in clocks for cmd_type 2'b01
T_LONG, 20, press length in clocks for cmd_type 2'b10
T_GAP, 8, release gap in clocks after every press (minimum 1)

Ports:
clk_i  input  1  system clock (100 MHz); all logic on rising edge
rst_i  input  1  reset, asynchronous, active-low
cmd_valid_i  input  1  press command valid
cmd_type_i  input  2  00 short, 01 normal, 10 long, 11 custom
cmd_len_i  input  NrBiti  press length for custom type; sampled at accept
cmd_ready_o  output  1  generator can accept a command
abort_i  input  1  cut the current press short
btn_o  output  1  generated button level, registered
busy_o  output  1  high in PRESS or GAP
done_o  output  1  one-cycle pulse when a command completes
aborted_o  output  1  qualifies done_o: completed command was aborted
press_cnt_o  output  8  count of completed non-aborted presses, wraps

Behaviour:
- Reset (rst_i=0, asynchronous): state IDLE; btn_o=0, busy_o=0, done_o=0, aborted_o=0, press_cnt_o=0, cmd_ready_o=1 after release. btn_o drops in the same instant reset asserts, including mid-press.
- States: IDLE, PRESS, GAP. cmd_ready_o = (state==IDLE). busy_o = (state!=IDLE). btn_o = registered (state==PRESS).
- Accept: at an edge with cmd_valid_i & cmd_ready_o. Latch L: T_SHORT, T_NORM, T_LONG, or cmd_len_i. Custom L=0 clamps to 1. Go to PRESS.
- btn_o is 1 for exactly L cycles, starting the cycle after accept.
- PRESS: down-counter loaded with L-1; at 0 go to GAP with counter loaded T_GAP-1.
- GAP: btn_o=0 for exactly T_GAP cycles. At counter 0 go to IDLE.
- On entering IDLE from GAP: done_o=1 for one cycle. aborted_o carries the command's abort flag for that same cycle and is 0 otherwise. press_cnt_o increments (mod 256) only if not aborted.
- Back-to-back: cmd_valid_i held high is accepted in the done_o cycle, so presses are separated by T_GAP+1 low cycles.
- Abort:
  - abort_i=1 in PRESS: next cycle btn_o=0, state GAP, gap counter restarts at T_GAP-1, abort flag set.
  - abort_i in GAP or IDLE: ignored.
  - abort_i in the last PRESS cycle: the press is treated as aborted (flag set); timing is identical to normal completion.
- Handshake rules:
  - cmd_* is ignored while cmd_ready_o=0; no queueing.
  - cmd_type_i/cmd_len_i need to be stable only in the accept cycle.
- Counter arithmetic: unsigned, width NrBiti. Lengths up to 2^NrBiti-1. Parameters exceeding this are a configuration error.

Test Plan:
- Reset then cmd_type=01 accepted at cycle 0 -> btn_o high cycles 1..10, low cycles 11..18, done_o=1 at cycle 19, aborted_o=0, press_cnt_o 0->1.
- Types 00 and 10 back-to-back with cmd_valid_i held -> btn_o high 5 cycles, 9 low, then high 20 cycles; drv_btn (same clk/rst) emits one srv_o pulse per press; press_cnt_o=2.
- Custom cmd_len_i=0 -> btn_o high exactly 1 cycle; custom cmd_len_i=63 -> high 63 cycles.
- abort_i=1 on 4th cycle of a long press -> btn_o high 4 cycles then low 8; done_o with aborted_o=1; press_cnt_o unchanged. abort_i during GAP -> no effect.
- rst_i asserted low mid-PRESS (asynchronously, between edges) -> btn_o=0 immediately, cmd_ready_o=1 after release, press_cnt_o=0, no done_o.
- 256 normal presses -> press_cnt_o wraps 255->0; cmd_valid_i pulsed while busy_o=1 -> command dropped, no extra press.
